// File: rtl/voice_alloc.sv
// voice_alloc: note-event voice allocator for a bank of ADSR voices.
// Accepts note-on/off events, chooses a target voice (same-note retrigger,
// free idle voice, oldest released voice, or steal the oldest voice), and
// drives each voice's gate and note number. Retriggering a gated voice
// drops its gate for RETRIG_GAP cycles so the envelope sees a fresh edge.
module voice_alloc #(
   parameter int NVOICES    = 4,
   parameter int NOTE_W     = 7,
   parameter int RETRIG_GAP = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      ev_valid,
   output logic                      ev_ready,
   input  logic                      ev_on,
   input  logic [NOTE_W-1:0]         ev_note,
   input  logic [NVOICES-1:0]        env_idle,
   output logic [NVOICES-1:0]        trig,
   output logic [NVOICES*NOTE_W-1:0] note,
   output logic                      all_gated
);

   localparam int IW = $clog2(NVOICES);
   localparam int GW = $clog2(RETRIG_GAP + 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DECIDE,
      S_GAP
   } state_t;

   state_t                      r_state;
   logic                        r_ev_on;
   logic [NOTE_W-1:0]           r_ev_note;
   logic [NVOICES-1:0]          r_trig;
   logic [NVOICES*NOTE_W-1:0]   r_note;
   logic [IW-1:0]               r_rank [NVOICES];
   logic [GW-1:0]               r_gap_cnt;
   logic [IW-1:0]               r_gap_voice;

   logic [NVOICES-1:0]          w_match;
   logic                        w_hit_a;
   logic                        w_hit_b;
   logic                        w_hit_c;
   logic [IW-1:0]               w_idx_a;
   logic [IW-1:0]               w_idx_b;
   logic [IW-1:0]               w_idx_c;
   logic [IW-1:0]               w_idx_d;
   logic [IW-1:0]               w_best_rank;
   logic [IW-1:0]               w_tgt;
   logic                        w_tgt_gated;

   // Target selection for the latched event; only consumed in DECIDE, so
   // env_idle has no influence at any other time.
   always_comb begin
      // NOTE: every signal gets a default before the loop so no path leaves
      // it unassigned; otherwise a latch would be inferred.
      w_match     = '0;
      w_hit_a     = 1'b0;
      w_hit_b     = 1'b0;
      w_hit_c     = 1'b0;
      w_idx_a     = '0;
      w_idx_b     = '0;
      w_idx_c     = '0;
      w_idx_d     = '0;
      w_best_rank = '0;
      for (int i = 0; i < NVOICES; i++) begin
         w_match[i] = r_trig[i] && (r_note[i*NOTE_W +: NOTE_W] == r_ev_note);
         // (a) gated voice already playing this note
         if (w_match[i] && !w_hit_a) begin
            w_hit_a = 1'b1;
            w_idx_a = IW'(i);
         end
         // (b) lowest-index released voice whose envelope has finished
         if (!r_trig[i] && env_idle[i] && !w_hit_b) begin
            w_hit_b = 1'b1;
            w_idx_b = IW'(i);
         end
         // (c) oldest released voice
         if (!r_trig[i] && (!w_hit_c || (r_rank[i] > w_best_rank))) begin
            w_hit_c     = 1'b1;
            w_idx_c     = IW'(i);
            w_best_rank = r_rank[i];
         end
         // (d) oldest voice overall
         if (r_rank[i] == IW'(NVOICES - 1)) begin
            w_idx_d = IW'(i);
         end
      end
      if (w_hit_a) begin
         w_tgt = w_idx_a;
      end else if (w_hit_b) begin
         w_tgt = w_idx_b;
      end else if (w_hit_c) begin
         w_tgt = w_idx_c;
      end else begin
         w_tgt = w_idx_d;
      end
      w_tgt_gated = r_trig[w_tgt];
   end

   // Allocation FSM: event latch, per-voice gate/note, LRU ranks, retrigger gap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_ev_on     <= 1'b0;
         r_ev_note   <= '0;
         r_trig      <= '0;
         r_note      <= '0;
         r_gap_cnt   <= '0;
         r_gap_voice <= '0;
         // NOTE: the rank array is reset like any register: the LRU order
         // must start as a valid permutation or selection breaks.
         for (int i = 0; i < NVOICES; i++) begin
            r_rank[i] <= IW'(i);
         end
      end else begin
         // NOTE: non-blocking assignments keep every register update in this
         // block reading the pre-edge values, so the rank shuffle is consistent.
         case (r_state)
            S_IDLE: begin
               if (ev_valid) begin
                  r_ev_on   <= ev_on;
                  r_ev_note <= ev_note;
                  r_state   <= S_DECIDE;
               end
            end
            S_DECIDE: begin
               if (r_ev_on) begin
                  r_note[w_tgt*NOTE_W +: NOTE_W] <= r_ev_note;
                  for (int i = 0; i < NVOICES; i++) begin
                     if (IW'(i) == w_tgt) begin
                        r_rank[i] <= '0;
                     end else if (r_rank[i] < r_rank[w_tgt]) begin
                        r_rank[i] <= r_rank[i] + 1'b1;
                     end
                  end
                  if (w_tgt_gated) begin
                     r_trig[w_tgt] <= 1'b0;
                     r_gap_voice   <= w_tgt;
                     r_gap_cnt     <= GW'(RETRIG_GAP - 1);
                     r_state       <= S_GAP;
                  end else begin
                     r_trig[w_tgt] <= 1'b1;
                     r_state       <= S_IDLE;
                  end
               end else begin
                  r_trig  <= r_trig & ~w_match;
                  r_state <= S_IDLE;
               end
            end
            S_GAP: begin
               if (r_gap_cnt == '0) begin
                  r_trig[r_gap_voice] <= 1'b1;
                  r_state             <= S_IDLE;
               end else begin
                  r_gap_cnt <= r_gap_cnt - 1'b1;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign ev_ready  = (r_state == S_IDLE) && !rst;
   assign trig      = r_trig;
   assign note      = r_note;
   assign all_gated = &r_trig;

endmodule

// File: doc/voice_alloc.md
VOICE_ALLOC -- requirements
Module: voice_alloc

Interface
REQ-001 Parameter NVOICES, default 4: number of ADSR voices served, range 2..8.
REQ-002 Parameter NOTE_W, default 7: note number width.
REQ-003 Parameter RETRIG_GAP, default 2: cycles trig is held low before re-gating a gated voice, range >=1.
REQ-004 clk  in  1  single system clock; all state on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 ev_valid  in  1  note event offered.
REQ-007 ev_ready  out  1  event accepted on an edge where ev_valid and ev_ready are both high.
REQ-008 ev_on  in  1  1 = note-on, 0 = note-off.
REQ-009 ev_note  in  NOTE_W  note number of the event.
REQ-010 env_idle  in  NVOICES  per voice, 1 when that voice's adsr envelope equals 0.
REQ-011 trig  out  NVOICES  per-voice gate to adsr.trig.
REQ-012 note  out  NVOICES*NOTE_W  per-voice note; voice i occupies bits [i*NOTE_W +: NOTE_W].
REQ-013 all_gated  out  1  high when every trig bit is high.

Function
REQ-014 FSM states: IDLE, DECIDE, GAP; ev_ready SHALL equal (state==IDLE) and SHALL be 0 while rst is high.
REQ-015 Acceptance edge k: IDLE->DECIDE, ev_on/ev_note latched; env_idle and trig SHALL be sampled during DECIDE (cycle k+1).
REQ-016 Each voice SHALL hold a unique LRU rank 0..NVOICES-1 (0 = newest); on allocation of voice v, v gets rank 0 and every voice with rank below v's old rank increments; note-off leaves ranks unchanged.
REQ-017 Note-on target selection, first match wins: (a) voice with trig high and note==ev_note; (b) lowest-index voice with trig low and env_idle high; (c) voice with trig low and highest rank; (d) voice with highest rank (steal).
REQ-018 Target with trig low (cases b, c): at edge k+2 trig[v]=1, note[v]=ev_note, ranks updated, DECIDE->IDLE.
REQ-019 Target with trig high (cases a, d): at edge k+2 trig[v]=0, note[v]=ev_note, ranks updated, DECIDE->GAP; trig[v] SHALL stay low exactly RETRIG_GAP cycles, then rise on the same edge that GAP->IDLE.
REQ-020 Note-off: at edge k+2 every voice with trig high and note==ev_note SHALL drop trig; note unchanged; DECIDE->IDLE; no match -> no output change.
REQ-021 At most one gated voice SHALL hold any note value at any time.
REQ-022 No output other than the target voice's trig/note SHALL change during DECIDE or GAP.
REQ-023 ev_ready SHALL be low for exactly 1 cycle per non-gated event and 1+RETRIG_GAP cycles per retrigger/steal.
REQ-024 env_idle changes outside DECIDE SHALL have no effect.
REQ-025 all_gated SHALL be combinational from trig.

Reset
REQ-026 While rst is high: trig=0, all note=0, rank of voice i = i, state=IDLE, gap counter=0, all_gated=0, regardless of state (including mid-GAP).
REQ-027 First event SHALL be acceptable on the first rising edge after rst deasserts.

Verification (NVOICES=4, NOTE_W=7, RETRIG_GAP=2, env_idle=4'b1111 unless stated)
REQ-028 Reset, note-on 60 accepted at edge k -> ev_ready low cycle k+1, trig=4'b0001 and note0=60 at edge k+2.
REQ-029 Note-on 60,62,64,67 -> voices 0,1,2,3, all_gated=1; note-off 62 -> trig=4'b1101; with env_idle=4'b0000, note-on 69 -> voice 1, note1=69, trig=4'b1111 with no gap.
REQ-030 All four gated (voice 0 oldest), note-on 72 -> trig[0] low at edge k+2 for 2 cycles, note0=72, trig[0] high at edge k+4, ev_ready low 3 cycles, other voices unchanged.
REQ-031 Voice 2 gated with 64, note-on 64 -> voice 2 retriggered (2-cycle low gap), no other voice changes; a following steal SHALL then skip voice 2 as newest.
REQ-032 Note-off 50 with no voice holding 50 -> trig and note unchanged, ev_ready low 1 cycle.
REQ-033 rst asserted during GAP -> trig=0 immediately (before next clock edge), ranks 0,1,2,3; note-on 60 after release -> voice 0.
